// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: op type layout, ROB id / data widths and the
// entry record. Wakeup-to-issue bypass is enabled by defining RS_WAKEUP_BYPASS_EN.
package alu_rs_pkg;

  localparam int unsigned ROB_ID_WIDTH = 32;
  localparam int unsigned DATA_WIDTH   = 32;

  // Type bits: branch [5], immediate [4], funct [3:1], alt [0].
  typedef struct packed {
    logic       branch;
    logic       use_imm;
    logic [2:0] funct;
    logic       alt;
  } op_type_t;

  localparam int unsigned RS_TYPE_WIDTH = $bits(op_type_t);

  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
  typedef logic [DATA_WIDTH-1:0]   data_t;

  typedef struct packed {
    logic     busy;
    rob_id_t  rob_id;
    op_type_t op_type;
    logic     qj_busy;
    rob_id_t  qj;
    data_t    vj;
    logic     qk_busy;
    rob_id_t  qk;
    data_t    vk;
    data_t    imm;
  } rs_entry_t;

  function automatic logic cdb_hit(input logic valid, input rob_id_t bus_id, input rob_id_t tag);
    return valid && (bus_id == tag);
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, result-bus and ALU-issue signals of the reservation station.
interface alu_rs_if import alu_rs_pkg::*; ();

  logic     disp_valid;
  rob_id_t  disp_rob_id;
  op_type_t disp_type;
  logic     disp_qj_busy;
  logic     disp_qk_busy;
  rob_id_t  disp_qj;
  rob_id_t  disp_qk;
  data_t    disp_vj;
  data_t    disp_vk;
  data_t    disp_imm;
  logic     full;

  logic     cdb0_valid;
  rob_id_t  cdb0_rob_id;
  data_t    cdb0_value;
  logic     cdb1_valid;
  rob_id_t  cdb1_rob_id;
  data_t    cdb1_value;

  logic     alu_en;
  rob_id_t  alu_rob_id;
  data_t    alu_data_j;
  data_t    alu_data_k;
  data_t    alu_imm;
  op_type_t alu_type;

  modport master (
    output disp_valid, disp_rob_id, disp_type, disp_qj_busy, disp_qk_busy, disp_qj, disp_qk,
           disp_vj, disp_vk, disp_imm,
    output cdb0_valid, cdb0_rob_id, cdb0_value, cdb1_valid, cdb1_rob_id, cdb1_value,
    input  full, alu_en, alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type
  );

  modport slave (
    input  disp_valid, disp_rob_id, disp_type, disp_qj_busy, disp_qk_busy, disp_qj, disp_qk,
           disp_vj, disp_vk, disp_imm,
    input  cdb0_valid, cdb0_rob_id, cdb0_value, cdb1_valid, cdb1_rob_id, cdb1_value,
    output full, alu_en, alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type
  );

endinterface

// File: rtl/alu_rs_pick.sv
// Find-first-set: reports whether any request bit is set and the lowest set index.
module alu_rs_pick #(
  parameter int unsigned Width    = 8,
  parameter int unsigned IdxWidth = 3
) (
  input  logic [Width-1:0]    req_i,
  output logic                valid_o,
  output logic [IdxWidth-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan downwards so the lowest set bit is the last to write.
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IdxWidth'(i);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops cdb0/cdb1 for operand wakeup and
// issues the lowest-index ready entry. RS_WAKEUP_BYPASS_EN lets a broadcast operand issue at once.
module alu_rs import alu_rs_pkg::*; #(
  parameter int unsigned RS_SIZE   = 8,
  parameter int unsigned IDX_WIDTH = 3
) (
  input logic     clk_in,
  input logic     rst_in,
  input logic     rdy_in,
  input logic     flush,
  alu_rs_if.slave bus
);

  rs_entry_t ent_q [RS_SIZE];
  rs_entry_t ent_d [RS_SIZE];

  logic [RS_SIZE-1:0] busy_vec, ready_vec, j_hit, k_hit;
  data_t              j_wval [RS_SIZE];
  data_t              k_wval [RS_SIZE];
  logic               free_valid, issue_valid, issue;
  logic [IDX_WIDTH-1:0] free_idx, issue_idx;
  logic               dj_hit, dk_hit;
  rs_entry_t          sel;

  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      busy_vec[i] = ent_q[i].busy;
      j_hit[i]  = ent_q[i].qj_busy &&
                  (cdb_hit(bus.cdb0_valid, bus.cdb0_rob_id, ent_q[i].qj) ||
                   cdb_hit(bus.cdb1_valid, bus.cdb1_rob_id, ent_q[i].qj));
      k_hit[i]  = ent_q[i].qk_busy &&
                  (cdb_hit(bus.cdb0_valid, bus.cdb0_rob_id, ent_q[i].qk) ||
                   cdb_hit(bus.cdb1_valid, bus.cdb1_rob_id, ent_q[i].qk));
      // cdb0 wins a tie between the two buses.
      j_wval[i] = cdb_hit(bus.cdb0_valid, bus.cdb0_rob_id, ent_q[i].qj) ?
                  bus.cdb0_value : bus.cdb1_value;
      k_wval[i] = cdb_hit(bus.cdb0_valid, bus.cdb0_rob_id, ent_q[i].qk) ?
                  bus.cdb0_value : bus.cdb1_value;
`ifdef RS_WAKEUP_BYPASS_EN
      ready_vec[i] = ent_q[i].busy && (!ent_q[i].qj_busy || j_hit[i]) &&
                     (!ent_q[i].qk_busy || k_hit[i]);
`else
      ready_vec[i] = ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
`endif
    end
  end

  alu_rs_pick #(.Width(RS_SIZE), .IdxWidth(IDX_WIDTH)) u_free_pick (
    .req_i   (~busy_vec),
    .valid_o (free_valid),
    .idx_o   (free_idx)
  );

  alu_rs_pick #(.Width(RS_SIZE), .IdxWidth(IDX_WIDTH)) u_issue_pick (
    .req_i   (ready_vec),
    .valid_o (issue_valid),
    .idx_o   (issue_idx)
  );

  assign bus.full = &busy_vec;
  assign issue    = rdy_in && !flush && issue_valid;
  assign sel      = ent_q[issue_idx];

  always_comb begin
    bus.alu_en     = issue;
    bus.alu_rob_id = '0;
    bus.alu_data_j = '0;
    bus.alu_data_k = '0;
    bus.alu_imm    = '0;
    bus.alu_type   = '0;
    if (issue) begin
      bus.alu_rob_id = sel.rob_id;
      bus.alu_data_j = sel.vj;
      bus.alu_data_k = sel.vk;
      bus.alu_imm    = sel.imm;
      bus.alu_type   = sel.op_type;
`ifdef RS_WAKEUP_BYPASS_EN
      if (sel.qj_busy) bus.alu_data_j = j_wval[issue_idx];
      if (sel.qk_busy) bus.alu_data_k = k_wval[issue_idx];
`endif
    end
  end

  assign dj_hit = bus.disp_qj_busy &&
                  (cdb_hit(bus.cdb0_valid, bus.cdb0_rob_id, bus.disp_qj) ||
                   cdb_hit(bus.cdb1_valid, bus.cdb1_rob_id, bus.disp_qj));
  assign dk_hit = bus.disp_qk_busy &&
                  (cdb_hit(bus.cdb0_valid, bus.cdb0_rob_id, bus.disp_qk) ||
                   cdb_hit(bus.cdb1_valid, bus.cdb1_rob_id, bus.disp_qk));

  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      for (int i = 0; i < int'(RS_SIZE); i++) ent_d[i].busy = 1'b0;
    end else begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (j_hit[i]) begin
          ent_d[i].qj_busy = 1'b0;
          ent_d[i].vj      = j_wval[i];
        end
        if (k_hit[i]) begin
          ent_d[i].qk_busy = 1'b0;
          ent_d[i].vk      = k_wval[i];
        end
      end
      if (issue) ent_d[issue_idx].busy = 1'b0;
      // The free slot is never the issuing one, since free pick sees registered busy only.
      if (bus.disp_valid && free_valid) begin
        ent_d[free_idx].busy    = 1'b1;
        ent_d[free_idx].rob_id  = bus.disp_rob_id;
        ent_d[free_idx].op_type = bus.disp_type;
        ent_d[free_idx].qj_busy = bus.disp_qj_busy && !dj_hit;
        ent_d[free_idx].qj      = bus.disp_qj;
        ent_d[free_idx].vj      = !dj_hit ? bus.disp_vj :
            (cdb_hit(bus.cdb0_valid, bus.cdb0_rob_id, bus.disp_qj) ? bus.cdb0_value
                                                                    : bus.cdb1_value);
        ent_d[free_idx].qk_busy = bus.disp_qk_busy && !dk_hit;
        ent_d[free_idx].qk      = bus.disp_qk;
        ent_d[free_idx].vk      = !dk_hit ? bus.disp_vk :
            (cdb_hit(bus.cdb0_valid, bus.cdb0_rob_id, bus.disp_qk) ? bus.cdb0_value
                                                                    : bus.cdb1_value);
        ent_d[free_idx].imm     = bus.disp_imm;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) ent_q[i] <= '0;
    end else if (rdy_in) begin
      ent_q <= ent_d;
    end
  end

endmodule
